// File: rtl/conv_window_gen_3x3.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_gen_3x3
// Brief    : Streaming 3x3 dilated/strided window generator with same-padding.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_gen_3x3 #(
    parameter int DATA_WIDTH  = 32,
    parameter int IMAGE_WIDTH = 32,
    parameter int RATE        = 1,
    parameter int STRIDE      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic [DATA_WIDTH-1:0]   pxl_in,
    output logic [9*DATA_WIDTH-1:0] win_out,
    output logic                    valid_out,
    output logic                    channel_done,
    output logic                    overrun
);
    localparam int c_lag   = IMAGE_WIDTH*RATE + RATE;
    localparam int c_size  = IMAGE_WIDTH*IMAGE_WIDTH;
    localparam int c_depth = 2*c_lag;
    localparam int c_pw    = $clog2(c_size + c_lag);
    localparam int c_cw    = $clog2(IMAGE_WIDTH);
    localparam int c_sw    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [c_pw-1:0] c_p_fill_last = c_pw'(c_lag - 1);
    localparam logic [c_pw-1:0] c_p_run_last  = c_pw'(c_size - 1);
    localparam logic [c_pw-1:0] c_p_last      = c_pw'(c_size + c_lag - 1);
    localparam logic [c_cw-1:0] c_col_last    = c_cw'(IMAGE_WIDTH - 1);
    localparam logic [c_cw-1:0] c_lo          = c_cw'(RATE);
    localparam logic [c_cw-1:0] c_hi          = c_cw'(IMAGE_WIDTH - 1 - RATE);
    localparam logic [c_sw-1:0] c_ph_last     = c_sw'(STRIDE - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                        r_state;
    logic [c_pw-1:0]               r_p;
    logic [c_cw-1:0]               r_rc;
    logic [c_cw-1:0]               r_cc;
    logic [c_sw-1:0]               r_rph;
    logic [c_sw-1:0]               r_cph;
    logic [c_depth*DATA_WIDTH-1:0] r_hist;

    logic                    w_adv;
    logic                    w_centre;
    logic                    w_emit;
    logic [DATA_WIDTH-1:0]   w_sample;
    logic [2:0]              w_row_ok;
    logic [2:0]              w_col_ok;
    logic [9*DATA_WIDTH-1:0] w_win;

    assign w_adv    = valid_in || (r_state == S_FLUSH);
    assign w_sample = (r_state == S_FLUSH) ? '0 : pxl_in;
    assign w_centre = (r_state != S_FILL);
    assign w_emit   = w_adv && w_centre && (r_rph == '0) && (r_cph == '0);
    assign w_row_ok = {r_rc <= c_hi, 1'b1, r_rc >= c_lo};
    assign w_col_ok = {r_cc <= c_hi, 1'b1, r_cc >= c_lo};

    // Tap (i,j) sits a fixed number of advances behind the incoming sample;
    // age 0 is the sample entering this cycle, age k is r_hist slot k-1.
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        for (genvar gj = 0; gj < 3; gj++) begin : g_col
            localparam int c_age = (2-gi)*RATE*IMAGE_WIDTH + (2-gj)*RATE;
            logic [DATA_WIDTH-1:0] w_raw;
            if (c_age == 0) begin : g_new
                assign w_raw = w_sample;
            end else begin : g_old
                assign w_raw = r_hist[(c_age-1)*DATA_WIDTH +: DATA_WIDTH];
            end
            assign w_win[(3*gi+gj)*DATA_WIDTH +: DATA_WIDTH] =
                (w_row_ok[gi] && w_col_ok[gj]) ? w_raw : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_FILL;
            r_p          <= '0;
            r_rc         <= '0;
            r_cc         <= '0;
            r_rph        <= '0;
            r_cph        <= '0;
            r_hist       <= '0;
            win_out      <= '0;
            valid_out    <= 1'b0;
            channel_done <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            valid_out    <= 1'b0;
            channel_done <= 1'b0;
            if (valid_in && (r_state == S_FLUSH)) begin
                overrun <= 1'b1;
            end
            if (w_adv) begin
                r_hist <= {r_hist[(c_depth-1)*DATA_WIDTH-1:0], w_sample};
                if (w_emit) begin
                    win_out   <= w_win;
                    valid_out <= 1'b1;
                end
                if (w_centre) begin
                    if (r_cc == c_col_last) begin
                        r_cc  <= '0;
                        r_cph <= '0;
                        r_rc  <= r_rc + 1'b1;
                        r_rph <= (r_rph == c_ph_last) ? '0 : r_rph + 1'b1;
                    end else begin
                        r_cc  <= r_cc + 1'b1;
                        r_cph <= (r_cph == c_ph_last) ? '0 : r_cph + 1'b1;
                    end
                end
                case (r_state)
                    S_FILL: begin
                        r_p <= r_p + 1'b1;
                        if (r_p == c_p_fill_last) r_state <= S_RUN;
                    end
                    S_RUN: begin
                        r_p <= r_p + 1'b1;
                        if (r_p == c_p_run_last) r_state <= S_FLUSH;
                    end
                    S_FLUSH: begin
                        if (r_p == c_p_last) begin
                            r_p          <= '0;
                            r_rc         <= '0;
                            r_cc         <= '0;
                            r_rph        <= '0;
                            r_cph        <= '0;
                            r_state      <= S_FILL;
                            channel_done <= 1'b1;
                        end else begin
                            r_p <= r_p + 1'b1;
                        end
                    end
                    default: r_state <= S_FILL;
                endcase
            end
        end
    end
endmodule
`default_nettype wire
